imsic_msi_receiver: RTL

IMSIC_MSI_RECEIVER -- requirements
Module: imsic_msi_receiver

---
 rtl/imsic_msi_receiver.sv | 138 +++++++++++++
 1 files changed

// File: rtl/imsic_msi_receiver.sv
// IMSIC interrupt-file MSI receiver: AXI-style write port, pending/enable, topei select.
// Optional macro IMSIC_BRESP_ERR_EN: address misses answer SLVERR instead of OKAY.
module imsic_msi_receiver #(
    parameter int          NR_INTP_IDS = 64,
    parameter logic [31:0] BASE_ADDR   = 32'h2400_0000,
    localparam int         IDW         = $clog2(NR_INTP_IDS)
) (
    input  logic                   i_clk,
    input  logic                   ni_rst,
    input  logic                   i_aw_valid,
    output logic                   o_aw_ready,
    input  logic [31:0]            i_aw_addr,
    input  logic                   i_w_valid,
    output logic                   o_w_ready,
    input  logic [31:0]            i_w_data,
    output logic                   o_b_valid,
    input  logic                   i_b_ready,
    output logic [1:0]             o_b_resp,
    input  logic [NR_INTP_IDS-1:0] i_eie,
    input  logic [IDW-1:0]         i_eithreshold,
    input  logic                   i_claim,
    output logic [IDW-1:0]         o_topei,
    output logic                   o_eip,
    output logic [NR_INTP_IDS-1:0] o_eip_pending
);

    typedef enum logic [1:0] {IDLE, GOT_AW, GOT_W, RESP} state_t;

    state_t                 state_q, state_d;
    logic                   aw_ready, w_ready, b_valid;
    logic                   aw_hs, w_hs, enter_resp, leave_resp;
    logic [31:0]            addr_q, data_q;
    logic [31:0]            eff_addr, eff_data;
    logic                   hit, in_range, set_en;
    logic [IDW-1:0]         set_idx;
    logic [1:0]             resp_q, resp_d;
    logic [NR_INTP_IDS-1:0] pending_q, pending_d;
    logic [IDW-1:0]         topei;
    logic                   unused_addr_bits;

    always_comb begin
        state_d  = state_q;
        aw_ready = 1'b0;
        w_ready  = 1'b0;
        b_valid  = 1'b0;
        unique case (state_q)
            IDLE: begin
                aw_ready = 1'b1;
                w_ready  = 1'b1;
                if (i_aw_valid && i_w_valid) state_d = RESP;
                else if (i_aw_valid)         state_d = GOT_AW;
                else if (i_w_valid)          state_d = GOT_W;
            end
            GOT_AW: begin
                w_ready = 1'b1;
                if (i_w_valid) state_d = RESP;
            end
            GOT_W: begin
                aw_ready = 1'b1;
                if (i_aw_valid) state_d = RESP;
            end
            RESP: begin
                b_valid = 1'b1;
                if (i_b_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign aw_hs      = i_aw_valid & aw_ready;
    assign w_hs       = i_w_valid & w_ready;
    assign enter_resp = (state_q != RESP) && (state_d == RESP);
    assign leave_resp = (state_q == RESP) && i_b_ready;

    // The completing beat is not yet in its register, so take it from the bus.
    assign eff_addr = aw_hs ? i_aw_addr : addr_q;
    assign eff_data = w_hs ? i_w_data : data_q;

    assign hit      = eff_addr[31:2] == BASE_ADDR[31:2];
    assign in_range = (eff_data != 32'd0) && (eff_data < 32'(NR_INTP_IDS));
    assign set_en   = enter_resp && hit && in_range;
    assign set_idx  = eff_data[IDW-1:0];

    assign unused_addr_bits = ^eff_addr[1:0];

`ifdef IMSIC_BRESP_ERR_EN
    assign resp_d = hit ? 2'b00 : 2'b10;
`else
    assign resp_d = 2'b00;
`endif

    always_comb begin
        topei = '0;
        for (int i = NR_INTP_IDS - 1; i > 0; i--) begin
            if (pending_q[i] && i_eie[i] &&
                (i_eithreshold == '0 || IDW'(i) < i_eithreshold))
                topei = IDW'(i);
        end
    end

    // Set after claim so a same-cycle set of the claimed identity wins.
    always_comb begin
        pending_d = pending_q;
        if (i_claim && topei != '0) pending_d[topei] = 1'b0;
        if (set_en) pending_d[set_idx] = 1'b1;
        pending_d[0] = 1'b0;
    end

    always_ff @(posedge i_clk or negedge ni_rst) begin
        if (!ni_rst) begin
            state_q   <= IDLE;
            pending_q <= '0;
            addr_q    <= '0;
            data_q    <= '0;
            resp_q    <= 2'b00;
        end else begin
            state_q   <= state_d;
            pending_q <= pending_d;
            if (leave_resp) begin
                addr_q <= '0;
                data_q <= '0;
            end else begin
                if (aw_hs) addr_q <= i_aw_addr;
                if (w_hs)  data_q <= i_w_data;
            end
            if (enter_resp) resp_q <= resp_d;
        end
    end

    assign o_aw_ready    = aw_ready;
    assign o_w_ready     = w_ready;
    assign o_b_valid     = b_valid;
    assign o_b_resp      = b_valid ? resp_q : 2'b00;
    assign o_topei       = topei;
    assign o_eip         = topei != '0;
    assign o_eip_pending = pending_q;

endmodule
